// File: rtl/fifo_wr_arbiter.sv
// Write-side controller for the async FIFO: round-robin write-port arbiter, binary/Gray write pointer, registered full flag.
// Optional packet-lock arbitration is enabled by defining FIFO_WR_ARB_PKT_LOCK_EN.
module fifo_wr_arbiter #(
  parameter int DATALEN = 8,
  parameter int ADDRLEN = 4,
  parameter int DEPTH   = 8,
  parameter int NREQ    = 4
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*DATALEN-1:0] req_data,
  input  logic [ADDRLEN-1:0]      wq2_rptr,
  output logic [NREQ-1:0]         gnt,
  output logic [DATALEN-1:0]      wdata,
  output logic                    wclken,
  output logic [ADDRLEN-2:0]      waddr,
  output logic [ADDRLEN-1:0]      wptr,
  output logic                    wfull
);
  localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NR = NREQ;

  if (DEPTH != (1 << (ADDRLEN - 1))) begin : g_depth_check
    $error("fifo_wr_arbiter: DEPTH must equal 2**(ADDRLEN-1)");
  end

  logic [ADDRLEN-1:0] wbin, wbin_nxt, wgray_nxt;
  logic [IW-1:0]      rr_ptr, rr_nxt, gnt_idx, idx_inc;
  logic               search_any, wr;
  logic [DATALEN-1:0] words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = req_data[g*DATALEN +: DATALEN];
  end

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  arb_state_t    state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic          locked;

  assign locked = (state == LOCKED);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Round-robin pointer only moves when a packet ends (or on a single-word packet).
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (wr) begin
          if (req_last[gnt_idx]) begin
            rr_nxt = idx_inc;
          end else begin
            owner_nxt = gnt_idx;
            state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (wr && req_last[owner]) begin
          state_nxt = IDLE;
          rr_nxt    = idx_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  logic          locked;
  logic [IW-1:0] owner;
  logic          unused_req_last;

  assign locked          = 1'b0;
  assign owner           = '0;
  assign unused_req_last = ^req_last;

  always_comb begin
    rr_nxt = rr_ptr;
    if (wr) rr_nxt = idx_inc;
  end
`endif

  always_comb begin
    int unsigned cand_w;
    search_any = 1'b0;
    gnt_idx    = '0;
    cand_w     = 0;
    for (int unsigned j = 0; j < NR; j++) begin
      cand_w = 32'(rr_ptr) + j;
      if (cand_w >= NR) cand_w = cand_w - NR;
      if (!search_any && req[IW'(cand_w)]) begin
        search_any = 1'b1;
        gnt_idx    = IW'(cand_w);
      end
    end
    if (locked) begin
      search_any = req[owner];
      gnt_idx    = owner;
    end
  end

  // Gating with wrst_n drops the grant asynchronously so no word is written during reset.
  assign wr      = search_any & ~wfull & wrst_n;
  assign idx_inc = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    gnt = '0;
    if (wr) gnt[gnt_idx] = 1'b1;
  end

  assign wdata     = wr ? words[gnt_idx] : '0;
  assign wclken    = wr;
  assign waddr     = wbin[ADDRLEN-2:0];
  assign wbin_nxt  = wbin + ADDRLEN'(wr);
  assign wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      rr_ptr <= '0;
    end else begin
      wbin   <= wbin_nxt;
      wptr   <= wgray_nxt;
      wfull  <= (wgray_nxt == {~wq2_rptr[ADDRLEN-1:ADDRLEN-2], wq2_rptr[ADDRLEN-3:0]});
      rr_ptr <= rr_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected grant/address/data/flags queued at drive time, compared at the falling edge.
module tb_fifo_wr_arbiter;
  localparam int DATALEN = 8;
  localparam int ADDRLEN = 4;
  localparam int DEPTH   = 8;
  localparam int NREQ    = 4;

  logic                    wclk = 1'b0;
  logic                    wrst_n;
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         req_last;
  logic [NREQ*DATALEN-1:0] req_data;
  logic [ADDRLEN-1:0]      wq2_rptr;
  logic [NREQ-1:0]         gnt;
  logic [DATALEN-1:0]      wdata;
  logic                    wclken;
  logic [ADDRLEN-2:0]      waddr;
  logic [ADDRLEN-1:0]      wptr;
  logic                    wfull;

  fifo_wr_arbiter #(
    .DATALEN(DATALEN),
    .ADDRLEN(ADDRLEN),
    .DEPTH  (DEPTH),
    .NREQ   (NREQ)
  ) dut (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .req     (req),
    .req_last(req_last),
    .req_data(req_data),
    .wq2_rptr(wq2_rptr),
    .gnt     (gnt),
    .wdata   (wdata),
    .wclken  (wclken),
    .waddr   (waddr),
    .wptr    (wptr),
    .wfull   (wfull)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [2:0] addr;
    logic [7:0] data;
    logic       full;
    logic [3:0] ptr;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] exp_wbin = '0;
  logic [3:0] h1 = '0, h2 = '0;
  logic [3:0] seq = '0;
  logic       track = 1'b0;

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DATALEN +: DATALEN] = {4'(i), seq};
  endtask

  // One cycle: drive at posedge+1, queue expectations, compare at negedge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] last, input logic [3:0] rp,
                     input logic [3:0] eg, input logic ef);
    exp_t e;
    req      = r;
    req_last = last;
    drive_data();
    wq2_rptr = track ? gray(h2) : rp;
    e.gnt  = eg;
    e.addr = exp_wbin[2:0];
    e.full = ef;
    e.ptr  = gray(exp_wbin);
    e.data = '0;
    for (int i = 0; i < NREQ; i++) if (eg[i]) e.data = {4'(i), seq};
    sb.push_back(e);
    h2 = h1;
    h1 = exp_wbin;
    if (eg != 4'b0) exp_wbin = exp_wbin + 4'd1;
    @(negedge wclk);
    e = sb.pop_front();
    check("gnt",    32'(gnt),    32'(e.gnt));
    check("wclken", 32'(wclken), 32'(e.gnt != 4'b0));
    check("waddr",  32'(waddr),  32'(e.addr));
    check("wdata",  32'(wdata),  32'(e.data));
    check("wfull",  32'(wfull),  32'(e.full));
    check("wptr",   32'(wptr),   32'(e.ptr));
    seq = seq + 4'd1;
    @(posedge wclk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_gnt"},    32'(gnt),    32'h0);
    check({tag, "_wclken"}, 32'(wclken), 32'h0);
    check({tag, "_wfull"},  32'(wfull),  32'h0);
    check({tag, "_wptr"},   32'(wptr),   32'h0);
    check({tag, "_waddr"},  32'(waddr),  32'h0);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    req    = '0;
    #1;
    reset_checks("rst");
    @(posedge wclk);
    #1;
    wrst_n   = 1'b1;
    exp_wbin = '0;
    h1 = '0;
    h2 = '0;
  endtask

  initial begin
    wrst_n   = 1'b0;
    req      = '0;
    req_last = '0;
    req_data = '0;
    wq2_rptr = '0;
    #1;
    reset_checks("init");
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;

    // Fairness with the read pointer trailing two cycles behind.
    track = 1'b1;
    for (int i = 0; i < 4; i++) cyc(4'b1010, 4'b0, 4'b0, (i % 2 == 0) ? 4'b0010 : 4'b1000, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b0100, 4'b0, 4'b0, 4'b0100, 1'b0);

    // Wrap: 20 more writes, never full; pointers wrap through 0.
    for (int i = 0; i < 20; i++) cyc(4'b0001, 4'b0, 4'b0, 4'b0001, 1'b0);

    // Reset asserted mid-write: outputs clear with no clock edge.
    req = 4'b1111;
    drive_data();
    #2;
    check("pre_rst_gnt", 32'(gnt), 32'(4'b0010));
    wrst_n = 1'b0;
    #1;
    reset_checks("midrst");
    check("midrst_wdata", 32'(wdata), 32'h0);
    @(posedge wclk);
    #1;
    wrst_n   = 1'b1;
    exp_wbin = '0;
    h1 = '0;
    h2 = '0;

    // Round-robin fill to full against a stationary read pointer.
    track = 1'b0;
    for (int i = 0; i < 8; i++) cyc(4'b1111, 4'b0, 4'b0000, 4'(1 << (i % 4)), 1'b0);
    cyc(4'b1111, 4'b0, 4'b0001, 4'b0000, 1'b1);
    cyc(4'b1111, 4'b0, 4'b0001, 4'b0001, 1'b0);
    cyc(4'b1111, 4'b0, 4'b0001, 4'b0000, 1'b1);

    // Packet of four words from requester 0 competing with requester 1.
    do_reset();
    track = 1'b1;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    cyc(4'b0011, 4'b0010, 4'b0, 4'b0001, 1'b0);
    cyc(4'b0011, 4'b0010, 4'b0, 4'b0001, 1'b0);
    cyc(4'b0011, 4'b0010, 4'b0, 4'b0001, 1'b0);
    cyc(4'b0011, 4'b0011, 4'b0, 4'b0001, 1'b0);
    cyc(4'b0011, 4'b0010, 4'b0, 4'b0010, 1'b0);
`else
    cyc(4'b0011, 4'b0010, 4'b0, 4'b0001, 1'b0);
    cyc(4'b0011, 4'b0010, 4'b0, 4'b0010, 1'b0);
    cyc(4'b0011, 4'b0010, 4'b0, 4'b0001, 1'b0);
    cyc(4'b0011, 4'b0011, 4'b0, 4'b0010, 1'b0);
    cyc(4'b0011, 4'b0010, 4'b0, 4'b0001, 1'b0);
`endif

    req = '0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side controller for the asynchronous FIFO's dual-port RAM. It shares the RAM's single write port among NREQ requesters with round-robin arbitration. It owns the binary/Gray write pointer and generates the registered full flag against the read pointer already synchronized into the write domain. It drives the RAM's wdata, wclken and waddr directly.

## Interface
- DATALEN, 8: width of one data word.
- ADDRLEN, 4: pointer width. RAM address is ADDRLEN-1 bits; the extra MSB is the wrap bit.
- DEPTH, 8: RAM depth. Must equal 2^(ADDRLEN-1).
- NREQ, 4: number of requesters, 2..8.

- wclk  in  1  write-domain clock; the only clock.
- wrst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  requester i has a word pending.
- req_last  in  NREQ  requester i's pending word ends a packet. Used only with packet lock.
- req_data  in  NREQ*DATALEN  packed words; requester i at [i*DATALEN +: DATALEN].
- wq2_rptr  in  ADDRLEN  Gray read pointer, already two-flop synchronized to wclk.
- gnt  out  NREQ  one-hot grant; req[i]&gnt[i] = word i written at this edge.
- wdata  out  DATALEN  to RAM; req_data of the granted requester, 0 when idle.
- wclken  out  1  to RAM; equals |gnt.
- waddr  out  ADDRLEN-1  to RAM; wbin[ADDRLEN-2:0].
- wptr  out  ADDRLEN  Gray write pointer, to the read-domain synchronizer.
- wfull  out  1  FIFO full, registered.

## Operation
- State after reset:
  - wbin = 0, wptr = 0, wfull = 0.
  - rr_ptr = 0 (requester 0 has highest priority).
  - Arbitration state IDLE, owner = 0.
- Grant search:
  - Combinational. Search starts at rr_ptr and proceeds upward modulo NREQ. The first i with req[i]=1 is granted.
  - gnt = 0 when wfull=1 or no request.
  - gnt[i] is never asserted without req[i].
- On a write (|gnt at the wclk edge):
  - wbin <= wbin+1, modulo 2^ADDRLEN.
  - wptr <= (wbin+1) ^ ((wbin+1)>>1).
  - rr_ptr <= (k+1) mod NREQ, where k is the granted index. Per-word mode only; see Configuration.
- Full flag:
  - wfull <= (wgraynext == {~wq2_rptr[ADDRLEN-1:ADDRLEN-2], wq2_rptr[ADDRLEN-3:0]}).
  - wgraynext is the Gray code of wbin + (|gnt).
  - wfull is recomputed every cycle, so it also clears when wq2_rptr advances.
- Boundary behaviour:
  - Wrap-around: waddr goes 7 -> 0 and the MSB of wbin toggles. No special handling.
  - Simultaneous write and read-pointer advance: both are folded into the same registered compare.
  - A requester dropping req while not granted loses nothing; its priority position is unchanged.
- Reset asserted mid-operation: all state and outputs clear immediately (gnt and wclken go low asynchronously). A word presented in that cycle is not written.

## Timing
- Grant-to-write latency: 0. gnt, wdata and wclken are valid in the same cycle as req. The RAM captures at that wclk edge.
- wptr and waddr update one cycle after the write.
- wfull asserts in the cycle after the write that fills the FIFO. No write is ever issued while wfull=1.
- wfull deasserts one cycle after wq2_rptr shows free space.
- Throughput: one word per cycle while not full.

## Configuration
- Macro: FIFO_WR_ARB_PKT_LOCK_EN.
- When defined, arbitration runs a packet-lock state machine with states IDLE and LOCKED.
  - IDLE: on a grant to k with req_last[k]=0, owner <= k and go to LOCKED. With req_last[k]=1, behave as per-word mode.
  - LOCKED: only the owner may be granted, even if it deasserts req (no timeout). Full stalls the owner but keeps the lock.
  - LOCKED exit: a granted write with req_last[owner]=1 returns to IDLE, and rr_ptr <= (owner+1) mod NREQ.
- When undefined:
  - req_last is ignored and no lock state exists.
  - rr_ptr advances after every grant.

## Test plan
- Reset: drive traffic, then pull wrst_n low mid-write. gnt, wclken, wfull, wptr and waddr go to 0 with no clock edge; after release, the first grant goes to requester 0.
- Round-robin fill: req=4'b1111, wq2_rptr=0. gnt sequence is 0001, 0010, 0100, 1000, repeating; waddr runs 0..7. After the 8th write, wfull=1, gnt=0 and wptr=4'b1100.
- Full release: from full, set wq2_rptr=4'b0001. The next cycle wfull=0 and exactly one write goes to waddr 0; the cycle after, wfull=1 again.
- Fairness: req=4'b1010 held. gnt alternates 0010, 1000. With req=4'b0100 alone, gnt=0100 every cycle.
- Wrap: 20 writes with wq2_rptr tracking wptr two cycles behind. wfull stays 0, waddr wraps 7 -> 0, and wptr returns to 4'b0000 after 16 writes.
- Packet lock (macro defined): req=4'b0011, requester 0 sends 4 words with req_last on the 4th. gnt is 0001 four times, then 0010. With the macro undefined, gnt alternates 0001, 0010.
